pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit.sv | 131 +++++++++++++
 tb/tb_pc_fetch_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter plus single-entry instruction fetch register.
//
// The PC drives a combinational instruction ROM. The decoded ROM fields for
// the current pc_out are captured into the if_* registers at the next rising
// clock edge.
//
// Ports
//   clk, reset_n           clock (rising edge) and asynchronous active-low reset
//   stall                  hold the PC and the fetch register
//   branch_taken           redirect the PC to branch_target and flush the fetch register
//   branch_target          redirect address
//   halt_req               enter HALT
//   pc_out                 current PC, drives the ROM address
//   rom_*                  decoded ROM fields for pc_out
//   if_valid, if_pc, if_*  fetch register: valid flag, address and captured fields
//   halted                 unit is in HALT
//   fetch_count            saturating count of captured instructions
module pc_fetch_unit #(
    parameter int unsigned PC_WIDTH = 16,
    parameter int unsigned PROG_LEN = 35,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                halt_req,
    output logic [PC_WIDTH-1:0] pc_out,
    input  logic                rom_format,
    input  logic [3:0]          rom_opcode,
    input  logic                rom_sign,
    input  logic [2:0]          rom_operand,
    input  logic [7:0]          rom_immediate,
    output logic                if_valid,
    output logic [PC_WIDTH-1:0] if_pc,
    output logic                if_format,
    output logic [3:0]          if_opcode,
    output logic                if_sign,
    output logic [2:0]          if_operand,
    output logic [7:0]          if_immediate,
    output logic                halted,
    output logic [15:0]         fetch_count
);

    typedef enum logic [0:0] {StRun, StHalt} state_t;

    // One extra bit so PROG_LEN == 2**PC_WIDTH still compares correctly.
    localparam logic [PC_WIDTH:0]   ProgLenExt = (PC_WIDTH + 1)'(PROG_LEN);
    localparam logic [PC_WIDTH-1:0] ResetPc    = PC_WIDTH'(RESET_PC);
    localparam logic [PC_WIDTH-1:0] PcOne      = PC_WIDTH'(1);

    state_t              state_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic                if_valid_q;
    logic [PC_WIDTH-1:0] if_pc_q;
    logic                if_format_q;
    logic [3:0]          if_opcode_q;
    logic                if_sign_q;
    logic [2:0]          if_operand_q;
    logic [7:0]          if_immediate_q;
    logic [15:0]         fetch_count_q;

    logic pc_out_of_range;
    assign pc_out_of_range = ({1'b0, pc_q} >= ProgLenExt);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StRun;
            pc_q           <= ResetPc;
            if_valid_q     <= 1'b0;
            if_pc_q        <= '0;
            if_format_q    <= 1'b0;
            if_opcode_q    <= '0;
            if_sign_q      <= 1'b0;
            if_operand_q   <= '0;
            if_immediate_q <= '0;
            fetch_count_q  <= '0;
        end else begin
            case (state_q)
                StRun: begin
                    if (halt_req) begin
                        state_q    <= StHalt;
                        if_valid_q <= 1'b0;
                    end else if (pc_out_of_range) begin
                        state_q    <= StHalt;
                        if_valid_q <= 1'b0;
                    end else if (branch_taken) begin
                        // Branch wins over stall: the held instruction is stale.
                        pc_q       <= branch_target;
                        if_valid_q <= 1'b0;
                    end else if (stall) begin
                        // Everything holds.
                    end else begin
                        pc_q           <= pc_q + PcOne;
                        if_valid_q     <= 1'b1;
                        if_pc_q        <= pc_q;
                        if_format_q    <= rom_format;
                        if_opcode_q    <= rom_opcode;
                        if_sign_q      <= rom_sign;
                        if_operand_q   <= rom_operand;
                        if_immediate_q <= rom_immediate;
                        if (fetch_count_q != 16'hFFFF) begin
                            fetch_count_q <= fetch_count_q + 16'd1;
                        end
                    end
                end
                StHalt: begin
                    // Only reset leaves HALT.
                    if_valid_q <= 1'b0;
                end
                default: begin
                    state_q    <= StHalt;
                    if_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign pc_out       = pc_q;
    assign if_valid     = if_valid_q;
    assign if_pc        = if_pc_q;
    assign if_format    = if_format_q;
    assign if_opcode    = if_opcode_q;
    assign if_sign      = if_sign_q;
    assign if_operand   = if_operand_q;
    assign if_immediate = if_immediate_q;
    assign halted       = (state_q == StHalt);
    assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a small combinational ROM model.
module tb_pc_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        halt_req;
    logic [15:0] pc_out;
    logic        rom_format;
    logic [3:0]  rom_opcode;
    logic        rom_sign;
    logic [2:0]  rom_operand;
    logic [7:0]  rom_immediate;
    logic        if_valid;
    logic [15:0] if_pc;
    logic        if_format;
    logic [3:0]  if_opcode;
    logic        if_sign;
    logic [2:0]  if_operand;
    logic [7:0]  if_immediate;
    logic        halted;
    logic [15:0] fetch_count;

    int errors = 0;
    int checks = 0;

    pc_fetch_unit #(
        .PC_WIDTH(16),
        .PROG_LEN(35),
        .RESET_PC(0)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .halt_req     (halt_req),
        .pc_out       (pc_out),
        .rom_format   (rom_format),
        .rom_opcode   (rom_opcode),
        .rom_sign     (rom_sign),
        .rom_operand  (rom_operand),
        .rom_immediate(rom_immediate),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_format    (if_format),
        .if_opcode    (if_opcode),
        .if_sign      (if_sign),
        .if_operand   (if_operand),
        .if_immediate (if_immediate),
        .halted       (halted),
        .fetch_count  (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 9-bit ROM word: {format, opcode[3:0], sign, operand[2:0]}; immediate is the low byte.
    function automatic logic [8:0] rom_word(input logic [15:0] a);
        logic [7:0] lo;
        lo = a[7:0] ^ 8'h5A;
        case (a)
            16'd0:   return 9'b000000001;
            16'd1:   return 9'b100010000;
            default: return {a[0], lo};
        endcase
    endfunction

    logic [8:0] rom_w;
    always_comb begin
        rom_w         = rom_word(pc_out);
        rom_format    = rom_w[8];
        rom_opcode    = rom_w[7:4];
        rom_sign      = rom_w[3];
        rom_operand   = rom_w[2:0];
        rom_immediate = rom_w[7:0];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
    endtask

    logic [8:0] w;

    initial begin
        reset_n       = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        halt_req      = 1'b0;

        // Reset values before any clock edge.
        #2;
        check("rst_pc", 32'(pc_out), 32'd0);
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_count", 32'(fetch_count), 32'd0);
        check("rst_if_pc", 32'(if_pc), 32'd0);
        check("rst_if_imm", 32'(if_immediate), 32'd0);
        #1;
        reset_n = 1'b1;

        // First two fetches.
        step();
        check("e1_valid", 32'(if_valid), 32'd1);
        check("e1_if_pc", 32'(if_pc), 32'd0);
        check("e1_format", 32'(if_format), 32'd0);
        check("e1_opcode", 32'(if_opcode), 32'd0);
        check("e1_operand", 32'(if_operand), 32'd1);
        step();
        check("e2_if_pc", 32'(if_pc), 32'd1);
        check("e2_format", 32'(if_format), 32'd1);
        check("e2_imm", 32'(if_immediate), 32'h10);
        check("e2_pc", 32'(pc_out), 32'd2);
        check("e2_count", 32'(fetch_count), 32'd2);

        // Run to pc_out=5, then stall for 3 cycles.
        step(); step(); step();
        check("pre_stall_pc", 32'(pc_out), 32'd5);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", 32'(pc_out), 32'd5);
            check("stall_if_pc", 32'(if_pc), 32'd4);
            check("stall_valid", 32'(if_valid), 32'd1);
            check("stall_count", 32'(fetch_count), 32'd5);
        end
        stall = 1'b0;
        step();
        w = rom_word(16'd5);
        check("resume_if_pc", 32'(if_pc), 32'd5);
        check("resume_opcode", 32'(if_opcode), 32'(w[7:4]));
        check("resume_sign", 32'(if_sign), 32'(w[3]));
        check("resume_count", 32'(fetch_count), 32'd6);

        // Branch together with stall at pc_out=7.
        step();
        check("pre_br_pc", 32'(pc_out), 32'd7);
        stall         = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 16'd20;
        step();
        stall        = 1'b0;
        branch_taken = 1'b0;
        check("br_pc", 32'(pc_out), 32'd20);
        check("br_valid", 32'(if_valid), 32'd0);
        check("br_count", 32'(fetch_count), 32'd7);
        step();
        check("br_if_pc", 32'(if_pc), 32'd20);
        check("br_if_valid", 32'(if_valid), 32'd1);
        check("br_pc_next", 32'(pc_out), 32'd21);

        // Free run from 0 to the end of the program.
        do_reset();
        for (int k = 1; k <= 35; k++) begin
            step();
            check("run_if_pc", 32'(if_pc), 32'(k - 1));
        end
        w = rom_word(16'd34);
        check("run_last_imm", 32'(if_immediate), 32'(w[7:0]));
        check("run_pc35", 32'(pc_out), 32'd35);
        step();
        check("oor_valid", 32'(if_valid), 32'd0);
        check("oor_halted", 32'(halted), 32'd1);
        check("oor_pc", 32'(pc_out), 32'd35);
        step(); step();
        check("oor_pc_hold", 32'(pc_out), 32'd35);
        check("oor_count", 32'(fetch_count), 32'd35);
        check("oor_if_pc_hold", 32'(if_pc), 32'd34);

        // halt_req at pc_out=10, then a branch that must be ignored.
        do_reset();
        for (int k = 0; k < 10; k++) step();
        check("pre_halt_pc", 32'(pc_out), 32'd10);
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_valid", 32'(if_valid), 32'd0);
        check("halt_pc", 32'(pc_out), 32'd10);
        branch_taken  = 1'b1;
        branch_target = 16'd3;
        step();
        branch_taken = 1'b0;
        check("halt_br_pc", 32'(pc_out), 32'd10);
        check("halt_br_halted", 32'(halted), 32'd1);
        check("halt_br_count", 32'(fetch_count), 32'd10);
        check("halt_br_if_pc", 32'(if_pc), 32'd9);
        // Asynchronous reset mid-cycle while halted.
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_halted", 32'(halted), 32'd0);
        check("arst_pc", 32'(pc_out), 32'd0);
        check("arst_count", 32'(fetch_count), 32'd0);
        check("arst_if_pc", 32'(if_pc), 32'd0);
        #1;
        reset_n = 1'b1;

        // Out-of-range branch target.
        step();
        check("ff_pre_pc", 32'(pc_out), 32'd1);
        branch_taken  = 1'b1;
        branch_target = 16'hFFFF;
        step();
        branch_taken = 1'b0;
        check("ff_pc", 32'(pc_out), 32'hFFFF);
        check("ff_valid", 32'(if_valid), 32'd0);
        check("ff_halted0", 32'(halted), 32'd0);
        step();
        check("ff_halted", 32'(halted), 32'd1);
        check("ff_valid2", 32'(if_valid), 32'd0);
        check("ff_count", 32'(fetch_count), 32'd1);
        check("ff_if_pc", 32'(if_pc), 32'd0);
        check("ff_pc_hold", 32'(pc_out), 32'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
